// File: rtl/button_move_encoder.sv
// -----------------------------------------------------------------------------
// button_move_encoder
//
// Turns four raw, bouncing push-buttons into single move commands for the maze
// FSM. Each button is synchronised (two flops), debounced (a counter of
// consecutive disagreeing samples) and edge-detected. Presses are arbitrated
// (Top > Bottom > Left > Right), encoded into a 2-bit direction and delivered
// once over a valid/ready handshake. Everything runs on clk.
//
// Ports:
//   clk          system clock (only clock)
//   reset        synchronous, active-high reset
//   btnTop       raw button inputs (asynchronous, bouncing)
//   btnBottom
//   btnLeft
//   btnRight
//   move_ready   consumer accepts the pending move this cycle
//   move_valid   a move command is pending
//   move_dir     00 Top, 01 Left, 10 Right, 11 Bottom
//   btn_db       debounced levels {Right, Left, Bottom, Top}
//   drop_pulse   one-cycle pulse when a press event is discarded
//
// Optional build macro AUTOREPEAT_EN: while the button that produced the last
// move stays held, the same move is re-presented after REPEAT_DELAY cycles in
// HOLD, then every REPEAT_PERIOD cycles. Without the macro the REPEAT_*
// parameters have no effect.
// -----------------------------------------------------------------------------
module button_move_encoder #(
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 15000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnTop,
    input  logic       btnBottom,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic [3:0] btn_db,
    output logic       drop_pulse
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time parameter sanity checks.
    if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be in 1..2^CNT_W-1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    // Bit order matches btn_db: {Right, Left, Bottom, Top}.
    logic [3:0] raw_vec;
    logic [3:0] db_vec;
    logic [3:0] press_vec;

    assign raw_vec = {btnRight, btnLeft, btnBottom, btnTop};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             db_reg;
            logic             press_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    db_reg    <= 1'b0;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw_vec[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (sync2_reg == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        // Level has disagreed for DEBOUNCE_CYCLES samples: accept it.
                        // The press strobe is raised in the same edge so the FSM
                        // sees it one cycle after btn_db rises.
                        db_reg    <= ~db_reg;
                        cnt_reg   <= '0;
                        press_reg <= ~db_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign db_vec[gi]    = db_reg;
            assign press_vec[gi] = press_reg;
        end
    endgenerate

    // Arbitration: lowest set bit wins (Top > Bottom > Left > Right).
    logic [1:0] win_dir;
    logic [3:0] press_rest;
    logic       multi_press;

    always_comb begin
        win_dir = 2'b00;
        if (press_vec[0])      win_dir = 2'b00;
        else if (press_vec[1]) win_dir = 2'b11;
        else if (press_vec[2]) win_dir = 2'b01;
        else if (press_vec[3]) win_dir = 2'b10;
    end

    // Clearing the lowest set bit leaves something only if >1 press is set.
    assign press_rest  = press_vec & (press_vec - 4'd1);
    assign multi_press = |press_rest;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] dir_reg, dir_next;
    logic       drop_next;
    logic       rpt_fire;

`ifdef AUTOREPEAT_EN
    localparam logic [31:0] RPT_DELAY_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RPT_PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

    logic [31:0] rpt_cnt_reg;
    logic        rpt_again_reg;
    logic        rpt_arm_reg;
    logic        orig_held;
    logic [31:0] rpt_last;

    // The originating button is recovered from the direction code itself.
    always_comb begin
        orig_held = 1'b0;
        case (dir_reg)
            2'b00:   orig_held = db_vec[0];
            2'b11:   orig_held = db_vec[1];
            2'b01:   orig_held = db_vec[2];
            default: orig_held = db_vec[3];
        endcase
    end

    assign rpt_last = rpt_again_reg ? RPT_PERIOD_LAST : RPT_DELAY_LAST;
    assign rpt_fire = (state_reg == HOLD) && rpt_arm_reg && orig_held &&
                      (rpt_cnt_reg == rpt_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_cnt_reg   <= '0;
            rpt_again_reg <= 1'b0;
            rpt_arm_reg   <= 1'b0;
        end else begin
            if (state_reg == IDLE && (|press_vec)) begin
                rpt_cnt_reg   <= '0;
                rpt_again_reg <= 1'b0;
                rpt_arm_reg   <= 1'b1;
            end else if (state_reg == HOLD) begin
                if (!orig_held) begin
                    // Releasing the originator ends auto-repeat for this move.
                    rpt_cnt_reg <= '0;
                    rpt_arm_reg <= 1'b0;
                end else if (rpt_fire) begin
                    // Later repeats count REPEAT_PERIOD from the next HOLD entry.
                    rpt_cnt_reg   <= '0;
                    rpt_again_reg <= 1'b1;
                end else if (rpt_arm_reg) begin
                    rpt_cnt_reg <= rpt_cnt_reg + 32'd1;
                end
            end
            // VALID: counter frozen.
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            dir_reg   <= 2'b00;
        end else begin
            state_reg <= state_next;
            dir_reg   <= dir_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        drop_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|press_vec) begin
                    state_next = VALID;
                    dir_next   = win_dir;
                    drop_next  = multi_press;
                end
            end
            VALID: begin
                drop_next = |press_vec;
                if (move_ready) state_next = HOLD;
            end
            HOLD: begin
                drop_next = |press_vec;
                if (db_vec == 4'b0000) state_next = IDLE;
                else if (rpt_fire)     state_next = VALID;
            end
            default: state_next = IDLE;
        endcase
    end

    assign move_valid = (state_reg == VALID);
    assign move_dir   = dir_reg;
    assign btn_db     = db_vec;
    assign drop_pulse = drop_next;

endmodule

// File: tb/tb_button_move_encoder.sv
module tb_button_move_encoder;

    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic [3:0] btn;        // {Right, Left, Bottom, Top}
    logic       move_ready;
    logic       move_valid;
    logic [1:0] move_dir;
    logic [3:0] btn_db;
    logic       drop_pulse;

    int checks   = 0;
    int failures = 0;

    button_move_encoder #(
        .CNT_W(8),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btnTop(btn[0]),
        .btnBottom(btn[1]),
        .btnLeft(btn[2]),
        .btnRight(btn[3]),
        .move_ready(move_ready),
        .move_valid(move_valid),
        .move_dir(move_dir),
        .btn_db(btn_db),
        .drop_pulse(drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Direction code for each button index, in priority order.
    localparam logic [1:0] DIR_OF [4] = '{2'b00, 2'b11, 2'b01, 2'b10};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------------
    // Behavioural reference: a button's accepted level flips once the
    // two-cycle-delayed raw level has disagreed with it for D consecutive
    // samples; a flip to 1 is a press seen by the move logic one cycle later.
    // The move logic is a "pending move" plus a "locked until all released".
    // ---------------------------------------------------------------------
    bit         m_raw_d1 [4];
    bit         m_raw_d2 [4];
    bit         m_db     [4];
    bit         m_press  [4];
    int         m_run    [4];
    bit         m_pending;
    bit         m_locked;
    logic [1:0] m_dir;

    always @(posedge clk) begin : model
        bit any_press;
        bit any_db;
        int first;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_raw_d1[i] = 0; m_raw_d2[i] = 0; m_db[i] = 0;
                m_press[i] = 0; m_run[i] = 0;
            end
            m_pending = 0; m_locked = 0; m_dir = 2'b00;
        end else begin
            any_press = 0; any_db = 0; first = -1;
            for (int i = 0; i < 4; i++) begin
                if (m_press[i]) begin
                    any_press = 1;
                    if (first < 0) first = i;
                end
                if (m_db[i]) any_db = 1;
            end
            if (m_pending) begin
                if (move_ready) begin
                    m_pending = 0;
                    m_locked  = 1;
                end
            end else if (m_locked) begin
                if (!any_db) m_locked = 0;
            end else if (any_press) begin
                m_pending = 1;
                m_dir     = DIR_OF[first];
            end
            for (int i = 0; i < 4; i++) begin
                m_press[i] = 0;
                if (m_raw_d2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_db[i]    = ~m_db[i];
                        m_press[i] = m_db[i];
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_raw_d2[i] = m_raw_d1[i];
                m_raw_d1[i] = btn[i];
            end
        end
    end

    function automatic logic model_drop();
        int n = 0;
        for (int i = 0; i < 4; i++) if (m_press[i]) n++;
        if (m_pending || m_locked) return n > 0;
        return n > 1;
    endfunction

    function automatic logic [3:0] model_db();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_db[i];
        return v;
    endfunction

    typedef struct {
        logic [3:0] btn;
        logic       ready;
        logic       exp_valid;
        logic [1:0] exp_dir;
        logic [3:0] exp_db;
        logic       exp_drop;
    } vec_t;

    vec_t tbl [20];

    initial begin : main
        int k;
        int first;
        int nvalid;
        int ndrop;
        int txn;

        // Left press then release, one row per clock edge.
        for (int i = 0; i < 20; i++) begin
            tbl[i].btn       = (i < 10) ? 4'b0100 : 4'b0000;
            tbl[i].ready     = 1'b1;
            tbl[i].exp_valid = (i == 6);
            tbl[i].exp_dir   = 2'b01;
            tbl[i].exp_db    = (i >= 5 && i < 15) ? 4'b0100 : 4'b0000;
            tbl[i].exp_drop  = 1'b0;
        end

        reset = 1'b1; btn = 4'b0000; move_ready = 1'b0;
        @(negedge clk);
        tick(); tick(); tick();
        chk("reset_valid", 32'(move_valid), 32'd0);
        chk("reset_dir",   32'(move_dir),   32'd0);
        chk("reset_db",    32'(btn_db),     32'd0);
        chk("reset_drop",  32'(drop_pulse), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            btn = tbl[i].btn; move_ready = tbl[i].ready;
            tick();
            chk($sformatf("tbl%0d_valid", i), 32'(move_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_db", i),    32'(btn_db),     32'(tbl[i].exp_db));
            chk($sformatf("tbl%0d_drop", i),  32'(drop_pulse), 32'(tbl[i].exp_drop));
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_dir", i), 32'(move_dir), 32'(tbl[i].exp_dir));
                $display("txn: left move dir=%b at row %0d", move_dir, i);
            end
        end

        // Bouncing Right: never stable for D cycles.
        for (int i = 0; i < 40; i++) begin
            btn = ((i / 2) % 2 == 0) ? 4'b1000 : 4'b0000;
            tick();
            chk("bounce_quiet", 32'({move_valid, btn_db[3]}), 32'd0);
        end
        btn = 4'b0000;
        for (int i = 0; i < 10; i++) tick();

        // Top and Bottom together: one Top move, one drop on the press cycle.
        move_ready = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 15; i++) begin
            btn = (i < 8) ? 4'b0011 : 4'b0000;
            tick();
            chk($sformatf("tb_drop%0d", i),  32'(drop_pulse), 32'(i == 5));
            chk($sformatf("tb_valid%0d", i), 32'(move_valid), 32'(i == 6));
            if (move_valid) begin
                nvalid++;
                chk("tb_dir", 32'(move_dir), 32'd0);
                $display("txn: arbitrated move dir=%b", move_dir);
            end
        end
        chk("tb_one_move", 32'(nvalid), 32'd1);
        for (int i = 0; i < 10; i++) tick();

        // Bottom with consumer stalled; Left pressed while pending is dropped.
        move_ready = 1'b0; btn = 4'b0010;
        k = -1;
        for (int i = 0; i < 20 && k < 0; i++) begin
            tick();
            if (move_valid) k = i;
        end
        chk("stall_latency", 32'(k), 32'd6);
        ndrop = 0;
        for (int j = 0; j < 20; j++) begin
            if (j == 2) btn = 4'b0110;
            if (j == 8) btn = 4'b0100;
            tick();
            chk("stall_valid", 32'(move_valid), 32'd1);
            chk("stall_dir",   32'(move_dir),   32'd3);
            if (drop_pulse) ndrop++;
        end
        chk("stall_drops", 32'(ndrop), 32'd1);
        move_ready = 1'b1; btn = 4'b0101;
        tick();
        $display("txn: stalled move accepted dir=11");
        chk("accept_clears", 32'(move_valid), 32'd0);
        nvalid = 0; ndrop = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (move_valid) nvalid++;
            if (drop_pulse) ndrop++;
        end
        chk("hold_no_move", 32'(nvalid), 32'd0);
        chk("hold_drop",    32'(ndrop),  32'd1);
        btn = 4'b0000;
        for (int j = 0; j < 12; j++) tick();

        // Reset while VALID with Bottom still held.
        move_ready = 1'b0; btn = 4'b0010;
        k = -1;
        for (int i = 0; i < 20 && k < 0; i++) begin
            tick();
            if (move_valid) k = i;
        end
        chk("rst_pre_valid", 32'(k), 32'd6);
        reset = 1'b1;
        tick();
        chk("rst_valid", 32'(move_valid), 32'd0);
        chk("rst_db",    32'(btn_db),     32'd0);
        reset = 1'b0;
        first = -1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (move_valid && first < 0) begin
                first = i;
                chk("rst_dir", 32'(move_dir), 32'd3);
                $display("txn: post-reset move dir=%b after %0d edges", move_dir, i);
            end
        end
        chk("rst_relatency", 32'(first), 32'(2 + D + 1));
        move_ready = 1'b1; btn = 4'b0000;
        for (int i = 0; i < 12; i++) tick();

`ifdef AUTOREPEAT_EN
        begin : autorepeat
            int exp_edges[$];
            int e;
            int db_fall;
            int got;
            // Release applied before edge 41 -> accepted level falls D+1 edges later.
            db_fall = 41 + 1 + D;
            e = 2 + D + 1;
            exp_edges.push_back(e);
            e += 11;
            while (e <= db_fall) begin
                exp_edges.push_back(e);
                e += 6;
            end
            got = 0;
            btn = 4'b1000;
            for (int i = 1; i <= 60; i++) begin
                if (i == 41) btn = 4'b0000;
                tick();
                if (move_valid) begin
                    $display("txn: repeat move dir=%b at edge %0d", move_dir, i);
                    chk("rpt_dir", 32'(move_dir), 32'd2);
                    chk("rpt_edge", 32'(i), 32'((got < exp_edges.size()) ? exp_edges[got] : -1));
                    got++;
                end
            end
            chk("rpt_count", 32'(got), 32'(exp_edges.size()));
        end
`else
        // Randomized traffic against the reference model.
        txn = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
            move_ready = ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 399) == 0);
            tick();
            chk("rnd_valid", 32'(move_valid), 32'(m_pending));
            chk("rnd_db",    32'(btn_db),     32'(model_db()));
            chk("rnd_drop",  32'(drop_pulse), 32'(model_drop()));
            if (m_pending) chk("rnd_dir", 32'(move_dir), 32'(m_dir));
            if (move_valid && move_ready && !reset) begin
                txn++;
                $display("txn %0d: move dir=%b accepted at %0t", txn, move_dir, $time);
            end
        end
        reset = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
